instr_fetch_ctrl: RTL and testbench

Fetch sequencer between the core front-end and the instruction memory request interface (req/addr/gnt/rvalid/rdata; memory answers one cycle after an accepted request). It keeps the fetch PC, issues word-aligned requests, and buffers returned words in a small FIFO tagged with PC and an error bit. It hands instructions to the decoder over a valid/ready handshake and handles branch redirects by flushing the FIFO and dropping in-flight responses.

---
 rtl/instr_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: issues word-aligned instruction requests and buffers
// the returned words, tagged with PC and fault, for the decoder.
module instr_fetch_ctrl #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int unsigned           FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic [WORD_WIDTH-1:0] instr_pc_o,
    output logic                  instr_err_o,
    output logic                  busy_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  outstanding_q, outstanding_d;
    logic                  discard_q, discard_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

    logic [WORD_WIDTH-1:0] buf_data_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] buf_pc_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] buf_err_q;

    logic [CW:0] inflight;
    logic        head_valid;
    logic        issue;
    logic        grant;
    logic        push;
    logic        fault;
    logic        pop;
    logic        unused_baddr_lsb;

    assign unused_baddr_lsb = ^branch_addr_i[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue uses the registered count only, so a push can never hit a full FIFO.
    always_comb begin
        inflight   = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
        head_valid = (count_q != '0);
        issue      = (state_q == RUN) && !branch_i
                     && (inflight < (CW+1)'(FIFO_DEPTH));
        grant      = issue && instr_gnt_i;
        push       = outstanding_q && !discard_q && !branch_i;
        fault      = push && !instr_rvalid_i;
        pop        = head_valid && instr_ready_i && !branch_i;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = grant;
        discard_d     = 1'b0;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case (state_q)
            IDLE: if (fetch_en_i) state_d = RUN;
            RUN: begin
                if (fault)            state_d = HALT;
                else if (!fetch_en_i) state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (grant) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WORD_WIDTH'(4);
        end
        // A redirect wins over everything: flush, drop the response, no pop.
        if (branch_i) begin
            state_d    = fetch_en_i ? RUN : IDLE;
            fetch_pc_d = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
            discard_d  = outstanding_q;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= BOOT_ADDR;
            req_pc_q      <= BOOT_ADDR;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= instr_rvalid_i ? instr_rdata_i : '0;
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
            buf_err_q[wr_ptr_q]  <= !instr_rvalid_i;
        end
    end

    assign instr_req_o   = issue;
    assign instr_addr_o  = fetch_pc_q;
    assign instr_valid_o = head_valid;
    assign instr_rdata_o = head_valid ? buf_data_q[rd_ptr_q] : '0;
    assign instr_pc_o    = head_valid ? buf_pc_q[rd_ptr_q] : '0;
    assign instr_err_o   = head_valid && buf_err_q[rd_ptr_q];
    assign busy_o        = (state_q == RUN) || outstanding_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a memory model answers grants,
// expected entries are queued at grant time and checked on delivery.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;
    logic        busy_o;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en_i     (fetch_en_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_pc_o     (instr_pc_o),
        .instr_err_o    (instr_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted on a fault.
    ent_t        expq[$];
    ent_t        pend;
    bit          pendv = 1'b0;
    int          mst = 0;
    logic [31:0] mpc = '0;
    logic [31:0] bad_addr = 32'hFFFF_FFF0;
    bit          stray = 1'b0;

    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic [31:0] got_err[$];
    logic [31:0] req_log[$];

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic bit mem_bad(input logic [31:0] a);
        return (a >= 32'h200) || (a == bad_addr);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    task automatic step(input bit en, input bit rdy, input bit gnt,
                        input bit br, input logic [31:0] ba);
        bit exp_req;
        bit fault;
        bit grant;
        @(posedge clk);
        #1;
        fetch_en_i    = en;
        instr_ready_i = rdy;
        instr_gnt_i   = gnt;
        branch_i      = br;
        branch_addr_i = ba;
        if (pendv) begin
            instr_rvalid_i = !pend.err;
            instr_rdata_i  = pend.err ? $urandom : pend.data;
        end else begin
            instr_rvalid_i = stray || ($urandom_range(0, 7) == 0);
            instr_rdata_i  = $urandom;
        end
        stray = 1'b0;
        exp_req = (mst == 1) && !br && (expq.size() + int'(pendv) < 3);
        #1;
        chk1("req", instr_req_o, exp_req);
        chk32("addr", instr_addr_o, mpc);
        chk1("busy", busy_o, (mst == 1) || pendv);
        if (instr_req_o && gnt) req_log.push_back(instr_addr_o);
        @(negedge clk);
        #1;
        fault = 1'b0;
        if (pendv && !br) begin
            expq.push_back(pend);
            fault = pend.err;
        end
        if (br) expq.delete();
        grant = exp_req && gnt;
        if (br)                     mst = en ? 1 : 0;
        else if (mst == 1 && fault) mst = 2;
        else if (mst == 1 && !en)   mst = 0;
        else if (mst == 0 && en)    mst = 1;
        pendv = grant;
        if (grant) begin
            pend.pc   = mpc;
            pend.err  = mem_bad(mpc);
            pend.data = pend.err ? 32'h0 : mem_word(mpc);
        end
        if (br)         mpc = {ba[31:2], 2'b00};
        else if (grant) mpc = mpc + 32'd4;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk1({nm, "_req"}, instr_req_o, 1'b0);
        chk32({nm, "_addr"}, instr_addr_o, 32'h0);
        chk1({nm, "_valid"}, instr_valid_o, 1'b0);
        chk32({nm, "_rdata"}, instr_rdata_o, 32'h0);
        chk32({nm, "_pc"}, instr_pc_o, 32'h0);
        chk1({nm, "_err"}, instr_err_o, 1'b0);
        chk1({nm, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b1;
        fetch_en_i     = 1'b0;
        branch_i       = 1'b0;
        branch_addr_i  = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_ready_i  = 1'b0;
        #1;
        check_zero_outputs("rst");
        mst   = 0;
        mpc   = 32'h0;
        pendv = 1'b0;
        expq.delete();
        @(negedge clk);
        #1;
        rst   = 1'b0;
        stray = 1'b1;
    endtask

    // Monitor: compares every delivered instruction with the queue head.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            chk1("valid", instr_valid_o, expq.size() != 0);
            if (!instr_valid_o) begin
                chk32("empty_pc", instr_pc_o, 32'h0);
                chk32("empty_rdata", instr_rdata_o, 32'h0);
                chk1("empty_err", instr_err_o, 1'b0);
            end else if (instr_ready_i && !branch_i && expq.size() != 0) begin
                e = expq.pop_front();
                chk32("pc", instr_pc_o, e.pc);
                chk32("rdata", instr_rdata_o, e.data);
                chk1("err", instr_err_o, e.err);
                got_pc.push_back(instr_pc_o);
                got_data.push_back(instr_rdata_o);
                got_err.push_back(32'(instr_err_o));
            end
        end
    end

    initial begin
        int rb;
        int gi;
        int fi;
        logic [31:0] resume_pc;
        #1 rst = 1'b1;
        #1 check_zero_outputs("por");
        do_reset();

        // straight-line fetch
        repeat (8) step(1, 1, 1, 0, 0);
        chk32("t1_pc0", qat(got_pc, 0), 32'h0);
        chk32("t1_pc1", qat(got_pc, 1), 32'h4);
        chk32("t1_pc2", qat(got_pc, 2), 32'h8);
        chk32("t1_d0", qat(got_data, 0), 32'h100);
        chk32("t1_d2", qat(got_data, 2), 32'h102);

        // backpressure
        do_reset();
        gi = got_pc.size();
        rb = req_log.size();
        repeat (8) step(1, 0, 1, 0, 0);
        chk32("t2_nreq", 32'(req_log.size() - rb), 32'd3);
        chk32("t2_a2", qat(req_log, rb + 2), 32'h8);
        chk1("t2_valid", instr_valid_o, 1'b1);
        chk32("t2_head", instr_pc_o, 32'h0);
        repeat (6) step(1, 1, 1, 0, 0);
        chk32("t2_pc0", qat(got_pc, gi), 32'h0);
        chk32("t2_pc2", qat(got_pc, gi + 2), 32'h8);
        chk32("t2_next", qat(req_log, rb + 3), 32'hC);

        // redirect with a response in flight
        gi = got_pc.size();
        rb = req_log.size();
        step(1, 1, 1, 1, 32'h1A);
        repeat (6) step(1, 1, 1, 0, 0);
        chk32("t3_req", qat(req_log, rb), 32'h18);
        chk32("t3_pc", qat(got_pc, gi), 32'h18);

        // fetch fault halts until a redirect
        bad_addr = 32'h40;
        gi = got_pc.size();
        step(1, 1, 1, 1, 32'h38);
        repeat (10) step(1, 1, 1, 0, 0);
        fi = -1;
        for (int k = gi; k < got_pc.size(); k++)
            if (got_pc[k] == 32'h40) fi = k;
        chk32("t4_fpc", qat(got_pc, fi), 32'h40);
        chk32("t4_ferr", qat(got_err, fi), 32'h1);
        chk32("t4_fdata", qat(got_data, fi), 32'h0);
        chk32("t4_last", qat(req_log, req_log.size() - 1), 32'h44);
        chk1("t4_noreq", instr_req_o, 1'b0);
        bad_addr = 32'hFFFF_FFF0;
        rb = req_log.size();
        step(1, 1, 1, 1, 32'h0);
        repeat (4) step(1, 1, 1, 0, 0);
        chk32("t4_resume", qat(req_log, rb), 32'h0);

        // fetch enable dropped with a grant pending
        repeat (3) step(1, 1, 1, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        chk1("t5_busy", busy_o, 1'b0);
        chk1("t5_req", instr_req_o, 1'b0);
        resume_pc = mpc;
        rb = req_log.size();
        repeat (4) step(1, 1, 1, 0, 0);
        chk32("t5_resume", qat(req_log, rb), resume_pc);

        // reset mid-stream
        repeat (3) step(1, 1, 1, 0, 0);
        do_reset();
        rb = req_log.size();
        repeat (4) step(1, 1, 1, 0, 0);
        chk32("t6_boot", qat(req_log, rb), 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 32'($urandom_range(0, 32'h27F)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
